// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: splits each 32-bit MEM-stage load/store into two halfword
// accesses (low half first) on a 16-bit asynchronous SRAM and freezes the
// pipeline via ready while the access is in flight.
module sram_mem_ctrl #(
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int unsigned ACCESS_CYCLES = 3,
    parameter int unsigned SRAM_AW       = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [15:0]        sram_dq_i,
    output logic [15:0]        sram_dq_o,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 wr_op_q, wr_op_d;
    logic [SRAM_AW-2:0]   idx_q, idx_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          read_data_q, read_data_d;
    logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
    logic [15:0]          dq_o_q, dq_o_d;
    logic                 oe_q, oe_d;
    logic                 we_n_q, we_n_d;
    logic [SRAM_AW-2:0]   idx_in;

    // Word index relative to the SRAM window; the cast drops high bits so
    // out-of-range addresses simply wrap around the device.
    assign idx_in = (SRAM_AW-1)'((address - BASE_ADDR) >> 2);

    // Next-state, pin and freeze decode; pins are computed one edge ahead so
    // they come straight out of registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_op_d     = wr_op_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        dq_o_d      = dq_o_q;
        oe_d        = oe_q;
        we_n_d      = we_n_q;
        ready       = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (rd_en | wr_en) begin
                    ready       = 1'b0;
                    state_d     = S_LOW;
                    cnt_d       = '0;
                    wr_op_d     = wr_en;
                    idx_d       = idx_in;
                    wdata_d     = write_data;
                    sram_addr_d = {idx_in, 1'b0};
                    if (wr_en) begin
                        dq_o_d = write_data[15:0];
                        oe_d   = 1'b1;
                        we_n_d = 1'b0;
                    end else begin
                        oe_d   = 1'b0;
                        we_n_d = 1'b1;
                    end
                end
            end
            S_LOW: begin
                ready = 1'b0;
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    state_d     = S_HIGH;
                    sram_addr_d = {idx_q, 1'b1};
                    dq_o_d      = wdata_q[31:16];
                    if (!wr_op_q) begin
                        read_data_d[15:0] = sram_dq_i;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                ready = 1'b0;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    oe_d    = 1'b0;
                    we_n_d  = 1'b1;
                    if (!wr_op_q) begin
                        read_data_d[31:16] = sram_dq_i;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                // Same instruction is still on rd_en/wr_en here, so ignore it.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_op_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_o_q      <= '0;
            oe_q        <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_op_q     <= wr_op_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_o_q      <= dq_o_d;
            oe_q        <= oe_d;
            we_n_q      <= we_n_d;
        end
    end

    assign read_data  = read_data_q;
    assign sram_addr  = sram_addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = oe_q;
    assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb_sram_mem_ctrl: drives directed and random loads/stores into
// sram_mem_ctrl, with a behavioural asynchronous SRAM on the pins and a
// word-level reference memory for expected load data.
module tb_sram_mem_ctrl;

    localparam int          AC   = 3;
    localparam int unsigned BASE = 1024;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_i;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic        sram_we_n;

    sram_mem_ctrl #(
        .BASE_ADDR    (1024),
        .ACCESS_CYCLES(3),
        .SRAM_AW      (18)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
        .ready     (ready),
        .sram_addr (sram_addr),
        .sram_dq_i (sram_dq_i),
        .sram_dq_o (sram_dq_o),
        .sram_dq_oe(sram_dq_oe),
        .sram_we_n (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: asynchronous read, write while we_n is low.
    logic [15:0] sram_mem [0:262143];
    int          wr_strobes = 0;
    assign sram_dq_i = sram_mem[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n) begin
            sram_mem[sram_addr] <= sram_dq_o;
            wr_strobes          <= wr_strobes + 1;
        end
    end

    // Word-level reference memory and last completed load value.
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return 17'((off / 4) % (32'd1 << 17));
    endfunction

    // Performs one access starting at a negedge; returns 1ns into the DONE
    // cycle with the request still held, as the stalled pipeline would.
    task automatic run_access(input logic w, input logic r, input logic [31:0] a,
                              input logic [31:0] d, input string tag);
        logic [16:0] idx;
        logic        half;
        int          n;
        idx        = word_idx(a);
        wr_en      = w;
        rd_en      = r;
        address    = a;
        write_data = d;
        n          = 0;
        #1;
        while (ready == 1'b0 && n < 20) begin
            if (n == 0) begin
                check_val({tag, " idle_we_n"}, 32'(sram_we_n), 32'd1);
                check_val({tag, " idle_oe"}, 32'(sram_dq_oe), 32'd0);
            end else begin
                half = (n > AC);
                check_val({tag, " addr"}, 32'(sram_addr), 32'({idx, half}));
                check_val({tag, " we_n"}, 32'(sram_we_n), w ? 32'd0 : 32'd1);
                check_val({tag, " oe"}, 32'(sram_dq_oe), 32'(w));
                if (w) begin
                    check_val({tag, " dq_o"}, 32'(sram_dq_o), half ? 32'(d[31:16]) : 32'(d[15:0]));
                end
            end
            n++;
            @(negedge clk);
            #1;
        end
        check_val({tag, " freeze"}, 32'(n), 32'(2 * AC + 1));
        check_val({tag, " done_we_n"}, 32'(sram_we_n), 32'd1);
        check_val({tag, " done_oe"}, 32'(sram_dq_oe), 32'd0);
        if (w) begin
            ref_mem[int'(idx)] = d;
            check_val({tag, " sram_lo"}, 32'(sram_mem[{idx, 1'b0}]), 32'(d[15:0]));
            check_val({tag, " sram_hi"}, 32'(sram_mem[{idx, 1'b1}]), 32'(d[31:16]));
        end else begin
            last_rd = ref_mem.exists(int'(idx)) ? ref_mem[int'(idx)] : 32'd0;
        end
        check_val({tag, " rdata"}, read_data, last_rd);
        $display("%s wr=%0d rd=%0d addr=%h idx=%h wdata=%h rdata=%h freeze=%0d",
                 tag, w, r, a, idx, d, read_data, n);
    endtask

    task automatic idle_gap();
        @(negedge clk);
        rd_en = 1'b0;
        wr_en = 1'b0;
        #1;
        check_val("idle_ready", 32'(ready), 32'd1);
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        int          k;
        k = $urandom_range(0, 15);
        a = BASE + 32'(4 * k);
        case ($urandom_range(0, 2))
            0: a = a + 32'($urandom_range(0, 3));
            1: a = a + (32'd1 << 19);
            default: a = a;
        endcase
        return a;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        logic        r;
        int          snap;
        rst        = 1'b1;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = '0;
        write_data = '0;
        last_rd    = '0;

        // Reset held for two edges.
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_ready", 32'(ready), 32'd1);
        check_val("rst_we_n", 32'(sram_we_n), 32'd1);
        check_val("rst_oe", 32'(sram_dq_oe), 32'd0);
        check_val("rst_rdata", read_data, 32'd0);
        check_val("rst_addr", 32'(sram_addr), 32'd0);
        check_val("rst_dq_o", 32'(sram_dq_o), 32'd0);
        rst = 1'b0;

        // Directed stores/loads, including a below-window address that wraps.
        @(negedge clk); run_access(1'b1, 1'b0, 32'd1024, 32'h0000060A, "ST");
        @(negedge clk); run_access(1'b0, 1'b1, 32'd1024, 32'h0, "LD");
        check_val("ld1024", read_data, 32'h0000060A);
        idle_gap();
        @(negedge clk); run_access(1'b1, 1'b0, 32'd1044, 32'hFFFFE7D8, "ST");
        check_val("sram10", 32'(sram_mem[18'd10]), 32'h0000E7D8);
        check_val("sram11", 32'(sram_mem[18'd11]), 32'h0000FFFF);
        @(negedge clk); run_access(1'b0, 1'b1, 32'd1044, 32'h0, "LD");
        check_val("ld1044", read_data, 32'hFFFFE7D8);
        @(negedge clk); run_access(1'b1, 1'b0, 32'd1020, 32'hA5C3_0F1E, "ST");
        @(negedge clk); run_access(1'b0, 1'b1, 32'd1020, 32'h0, "LD");

        // rd_en held through DONE must not start a second access.
        @(negedge clk); run_access(1'b0, 1'b1, 32'd1044, 32'h0, "LD");
        idle_gap();
        @(negedge clk);
        #1;
        check_val("done_ignored", 32'(ready), 32'd1);
        @(negedge clk); run_access(1'b0, 1'b1, 32'd1024, 32'h0, "LD");
        @(negedge clk); run_access(1'b0, 1'b1, 32'd1020, 32'h0, "LD");

        // Both enables: the write wins.
        @(negedge clk); run_access(1'b1, 1'b1, 32'd1028, 32'h1234_5678, "RW");
        @(negedge clk); run_access(1'b0, 1'b1, 32'd1028, 32'h0, "LD");
        check_val("rw_wins", read_data, 32'h1234_5678);

        // Prefill the random pool so every later load has known data.
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); run_access(1'b1, 1'b0, BASE + 32'(4 * k), $urandom, "PF");
        end

        // Random traffic with occasional idle cycles.
        for (int t = 0; t < 40; t++) begin
            a = pick_addr();
            d = $urandom;
            case ($urandom_range(0, 2))
                0: begin w = 1'b0; r = 1'b1; end
                1: begin w = 1'b1; r = 1'b0; end
                default: begin w = 1'b1; r = 1'b1; end
            endcase
            if ($urandom_range(0, 3) == 0) idle_gap();
            @(negedge clk); run_access(w, r, a, d, "RND");
        end

        // Reset on the second HIGH cycle of a store aborts it.
        idle_gap();
        @(negedge clk);
        wr_en      = 1'b1;
        rd_en      = 1'b0;
        address    = BASE + 32'd400;
        write_data = 32'hDEAD_BEEF;
        for (int c = 0; c < 2 * AC - 1; c++) @(negedge clk);
        #1;
        check_val("abort_pre_we_n", 32'(sram_we_n), 32'd0);
        check_val("abort_pre_addr", 32'(sram_addr), 32'({word_idx(BASE + 32'd400), 1'b1}));
        rst   = 1'b1;
        wr_en = 1'b0;
        @(negedge clk);
        #1;
        check_val("abort_ready", 32'(ready), 32'd1);
        check_val("abort_we_n", 32'(sram_we_n), 32'd1);
        check_val("abort_oe", 32'(sram_dq_oe), 32'd0);
        check_val("abort_rdata", read_data, 32'd0);
        snap    = wr_strobes;
        rst     = 1'b0;
        last_rd = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check_val("abort_no_writes", 32'(wr_strobes), 32'(snap));
        check_val("abort_idle_ready", 32'(ready), 32'd1);
        $display("ABORT addr=%h strobes=%0d", BASE + 32'd400, wr_strobes);

        // Recovery: a normal load afterwards.
        @(negedge clk); run_access(1'b0, 1'b1, BASE + 32'd8, 32'h0, "LD");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
